// File: rtl/wave_pkg.sv
// Shared constants for the wave oscillator: waveform mode encoding and width-derived
// reset defaults.
package wave_pkg;

  typedef enum logic [1:0] {
    MODE_SAW = 2'b00,
    MODE_TRI = 2'b01,
    MODE_SQR = 2'b10,
    MODE_OFF = 2'b11
  } wave_mode_e;

  // 2^(w-1) in a wide container; callers cast down to their own width.
  function automatic logic [63:0] midpoint(input int unsigned w);
    return 64'(1) << (w - 1);
  endfunction

  function automatic logic [63:0] duty_default(input int unsigned acc_w);
    return midpoint(acc_w);
  endfunction

  function automatic logic [63:0] out_midscale(input int unsigned out_w);
    return midpoint(out_w);
  endfunction

endpackage

// File: rtl/tick_div.sv
// Enabled sample-rate divider: one-cycle tick every div+1 enabled cycles.
module tick_div #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;

  // div is sampled live; >= keeps a shrinking div from running the counter past it.
  assign tick = enable && (cnt_q >= div);

  always_ff @(posedge clk) begin
    if (rst || !enable || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + DIV_W'(1);
    end
  end

endmodule

// File: rtl/wave_osc.sv
// Phase-accumulator oscillator (saw/triangle/square/silent) with a handshaked config
// that only takes effect at a phase wrap.
module wave_osc
  import wave_pkg::*;
#(
  parameter int unsigned OUT_W = 8,
  parameter int unsigned ACC_W = 16,
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [DIV_W-1:0] div,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [ACC_W-1:0] cfg_step,
  input  logic [1:0]       cfg_mode,
  input  logic [ACC_W-1:0] cfg_duty,
  output logic [OUT_W-1:0] out,
  output logic             out_valid,
  output logic             wrap
);

  localparam logic [ACC_W-1:0] DutyRst = ACC_W'(duty_default(ACC_W));
  localparam logic [OUT_W-1:0] OutMid  = OUT_W'(out_midscale(OUT_W));

  logic tick;

  tick_div #(
    .DIV_W(DIV_W)
  ) u_tick_div (
    .clk   (clk),
    .rst   (rst),
    .enable(enable),
    .div   (div),
    .tick  (tick)
  );

  logic [ACC_W-1:0] acc_q, step_q, duty_q;
  wave_mode_e       mode_q;
  logic             pend_q;
  logic [ACC_W-1:0] pend_step_q, pend_duty_q;
  wave_mode_e       pend_mode_q;
  logic [OUT_W-1:0] out_q;
  logic             out_valid_q, wrap_q;

  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc_nxt;
  logic             carry;
  logic             accept;
  logic             apply;
  logic [OUT_W-1:0] tri_t;
  logic [OUT_W-1:0] wave;

  assign sum     = {1'b0, acc_q} + {1'b0, step_q};
  assign acc_nxt = sum[ACC_W-1:0];
  assign carry   = sum[ACC_W];

  assign cfg_ready = !pend_q;
  assign accept    = cfg_valid && !pend_q;
  // When no wrap can be relied on (frozen or silent), apply right away.
  assign apply     = pend_q && ((tick && carry) || !enable || (mode_q == MODE_OFF));

  assign tri_t = acc_nxt[ACC_W-2 -: OUT_W];

  always_comb begin
    wave = OutMid;
    case (mode_q)
      MODE_SAW: wave = acc_nxt[ACC_W-1 -: OUT_W];
      MODE_TRI: wave = acc_nxt[ACC_W-1] ? ~tri_t : tri_t;
      MODE_SQR: wave = (acc_nxt < duty_q) ? '1 : '0;
      default:  wave = OutMid;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      step_q      <= '0;
      mode_q      <= MODE_OFF;
      duty_q      <= DutyRst;
      pend_q      <= 1'b0;
      pend_step_q <= '0;
      pend_mode_q <= MODE_OFF;
      pend_duty_q <= DutyRst;
      out_q       <= OutMid;
      out_valid_q <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      out_valid_q <= tick;
      wrap_q      <= tick && carry;
      if (tick) begin
        acc_q <= acc_nxt;
        out_q <= wave;
      end
      if (accept) begin
        pend_q      <= 1'b1;
        pend_step_q <= cfg_step;
        pend_mode_q <= wave_mode_e'(cfg_mode);
        pend_duty_q <= cfg_duty;
      end else if (apply) begin
        pend_q <= 1'b0;
        step_q <= pend_step_q;
        mode_q <= pend_mode_q;
        duty_q <= pend_duty_q;
      end
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_wave_osc.sv
// Directed vector bench for wave_osc at OUT_W=8, ACC_W=16, DIV_W=8.
module tb_wave_osc;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [7:0]  div;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [15:0] cfg_step;
  logic [1:0]  cfg_mode;
  logic [15:0] cfg_duty;
  logic [7:0]  out_s;
  logic        out_valid;
  logic        wrap;

  wave_osc #(
    .OUT_W(8),
    .ACC_W(16),
    .DIV_W(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .div      (div),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_step (cfg_step),
    .cfg_mode (cfg_mode),
    .cfg_duty (cfg_duty),
    .out      (out_s),
    .out_valid(out_valid),
    .wrap     (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          en;
    logic [7:0]  div;
    bit          cfg;
    logic [15:0] step;
    logic [1:0]  mode;
    logic [15:0] duty;
    int          cycles;
    logic [7:0]  e_out;
    bit          e_val;
    bit          e_wrap;
    bit          e_rdy;
  } vec_t;

  vec_t vecs[$];
  int   n_run  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(bit r, bit en, logic [7:0] dv, bit cf, logic [15:0] st,
                              logic [1:0] md, logic [15:0] dt, int cyc, logic [7:0] eo,
                              bit ev, bit ew, bit er);
    vec_t v;
    v.rst = r; v.en = en; v.div = dv; v.cfg = cf; v.step = st; v.mode = md; v.duty = dt;
    v.cycles = cyc; v.e_out = eo; v.e_val = ev; v.e_wrap = ew; v.e_rdy = er;
    return v;
  endfunction

  // Free-running: en=1 div=0 no cfg.
  function automatic vec_t run(int cyc, logic [7:0] eo, bit ev, bit ew, bit er);
    return mk(0, 1, 8'd0, 0, 16'h0, 2'b00, 16'h8000, cyc, eo, ev, ew, er);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    int strobes, highs, wraps;

    // Reset state
    vecs.push_back(mk(0, 0, 8'd0, 0, 16'h0,    2'b11, 16'h8000, 0,   8'h80, 0, 0, 1));
    // Saw 0x0100, configured while frozen so it applies the next cycle
    vecs.push_back(mk(0, 0, 8'd0, 1, 16'h0100, 2'b00, 16'h8000, 1,   8'h80, 0, 0, 0));
    vecs.push_back(mk(0, 0, 8'd0, 0, 16'h0,    2'b00, 16'h8000, 1,   8'h80, 0, 0, 1));
    vecs.push_back(run(1,   8'h01, 1, 0, 1));
    vecs.push_back(run(1,   8'h02, 1, 0, 1));
    vecs.push_back(run(125, 8'h7F, 1, 0, 1));
    vecs.push_back(run(128, 8'hFF, 1, 0, 1));
    vecs.push_back(run(1,   8'h00, 1, 1, 1));
    vecs.push_back(run(1,   8'h01, 1, 0, 1));
    vecs.push_back(run(126, 8'h7F, 1, 0, 1));
    // New step 0x0400 accepted as acc reaches 0x8000; old step until wrap
    vecs.push_back(mk(0, 1, 8'd0, 1, 16'h0400, 2'b00, 16'h8000, 1, 8'h80, 1, 0, 0));
    vecs.push_back(run(1,   8'h81, 1, 0, 0));
    vecs.push_back(run(125, 8'hFE, 1, 0, 0));
    vecs.push_back(run(1,   8'hFF, 1, 0, 0));
    vecs.push_back(run(1,   8'h00, 1, 1, 1));
    vecs.push_back(run(1,   8'h04, 1, 0, 1));
    vecs.push_back(run(1,   8'h08, 1, 0, 1));
    // Freeze: output and phase hold, no strobes
    vecs.push_back(mk(0, 0, 8'd0, 0, 16'h0,    2'b00, 16'h8000, 3, 8'h08, 0, 0, 1));
    vecs.push_back(run(1,   8'h0C, 1, 0, 1));
    // Reset with a pending config: discarded, silent afterwards
    vecs.push_back(mk(0, 1, 8'd0, 1, 16'h0200, 2'b01, 16'h8000, 1, 8'h10, 1, 0, 0));
    vecs.push_back(mk(1, 1, 8'd0, 0, 16'h0,    2'b00, 16'h8000, 1, 8'h80, 0, 0, 1));
    vecs.push_back(run(3,   8'h80, 1, 0, 1));
    // Triangle 0x0200
    vecs.push_back(mk(0, 0, 8'd0, 1, 16'h0200, 2'b01, 16'h8000, 1, 8'h80, 0, 0, 0));
    vecs.push_back(mk(0, 0, 8'd0, 0, 16'h0,    2'b00, 16'h8000, 1, 8'h80, 0, 0, 1));
    vecs.push_back(run(1,   8'h04, 1, 0, 1));
    vecs.push_back(run(62,  8'hFC, 1, 0, 1));
    vecs.push_back(run(1,   8'hFF, 1, 0, 1));
    vecs.push_back(run(1,   8'hFB, 1, 0, 1));
    vecs.push_back(run(62,  8'h03, 1, 0, 1));
    vecs.push_back(run(1,   8'h00, 1, 1, 1));
    vecs.push_back(run(127, 8'h03, 1, 0, 1));
    // Config accepted on the wrap edge: applies only at the following wrap
    vecs.push_back(mk(0, 1, 8'd0, 1, 16'h0100, 2'b00, 16'h8000, 1, 8'h00, 1, 1, 0));
    vecs.push_back(run(1,   8'h04, 1, 0, 0));
    vecs.push_back(run(126, 8'h03, 1, 0, 0));
    vecs.push_back(run(1,   8'h00, 1, 1, 1));
    vecs.push_back(run(1,   8'h01, 1, 0, 1));
    // Square duty 0x4000, step 0x1000, div=3
    vecs.push_back(mk(1, 0, 8'd0, 0, 16'h0,    2'b00, 16'h8000, 1, 8'h80, 0, 0, 1));
    vecs.push_back(mk(0, 0, 8'd0, 1, 16'h1000, 2'b10, 16'h4000, 1, 8'h80, 0, 0, 0));
    vecs.push_back(mk(0, 0, 8'd0, 0, 16'h0,    2'b00, 16'h8000, 1, 8'h80, 0, 0, 1));
    vecs.push_back(mk(0, 1, 8'd3, 0, 16'h0,    2'b00, 16'h8000, 3, 8'h80, 0, 0, 1));
    vecs.push_back(mk(0, 1, 8'd3, 0, 16'h0,    2'b00, 16'h8000, 1, 8'hFF, 1, 0, 1));
    vecs.push_back(mk(0, 1, 8'd3, 0, 16'h0,    2'b00, 16'h8000, 1, 8'hFF, 0, 0, 1));
    vecs.push_back(mk(0, 1, 8'd3, 0, 16'h0,    2'b00, 16'h8000, 3, 8'hFF, 1, 0, 1));
    vecs.push_back(mk(0, 1, 8'd3, 0, 16'h0,    2'b00, 16'h8000, 4, 8'hFF, 1, 0, 1));
    vecs.push_back(mk(0, 1, 8'd3, 0, 16'h0,    2'b00, 16'h8000, 4, 8'h00, 1, 0, 1));
    vecs.push_back(mk(0, 1, 8'd3, 0, 16'h0,    2'b00, 16'h8000, 44, 8'h00, 1, 0, 1));
    vecs.push_back(mk(0, 1, 8'd3, 0, 16'h0,    2'b00, 16'h8000, 4, 8'hFF, 1, 1, 1));

    rst = 1'b1; enable = 1'b0; div = 8'd0;
    cfg_valid = 1'b0; cfg_step = '0; cfg_mode = 2'b00; cfg_duty = '0;
    repeat (2) @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      rst = vecs[i].rst; enable = vecs[i].en; div = vecs[i].div;
      cfg_valid = vecs[i].cfg; cfg_step = vecs[i].step;
      cfg_mode = vecs[i].mode; cfg_duty = vecs[i].duty;
      for (int c = 0; c < vecs[i].cycles; c++) begin
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
      end
      n_run++;
      if (out_s !== vecs[i].e_out || out_valid !== vecs[i].e_val ||
          wrap !== vecs[i].e_wrap || cfg_ready !== vecs[i].e_rdy) begin
        n_fail++;
        $display("FAIL vec%0d: got out=%h valid=%b wrap=%b ready=%b, want out=%h valid=%b wrap=%b ready=%b",
                 i, out_s, out_valid, wrap, cfg_ready,
                 vecs[i].e_out, vecs[i].e_val, vecs[i].e_wrap, vecs[i].e_rdy);
      end
    end

    // One full square period at div=3: 16 strobes, 4 high samples, 1 wrap in 64 cycles
    strobes = 0; highs = 0; wraps = 0;
    for (int c = 0; c < 64; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        strobes++;
        if (out_s == 8'hFF) highs++;
      end
      if (wrap) wraps++;
      if (wrap && !out_valid) begin
        n_fail++;
        $display("FAIL wrap_without_valid: cycle %0d wrap=1 valid=0, want valid=1", c);
      end
    end
    n_run++;
    if (strobes != 16) begin
      n_fail++;
      $display("FAIL sqr_strobes: got %0d, want 16", strobes);
    end
    n_run++;
    if (highs != 4) begin
      n_fail++;
      $display("FAIL sqr_high_samples: got %0d, want 4", highs);
    end
    n_run++;
    if (wraps != 1) begin
      n_fail++;
      $display("FAIL sqr_wraps: got %0d, want 1", wraps);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
